// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 max-pool over CO parallel channels of a raster feature map.
// Optional build macro MAXPOOL_SIGNED_EN switches element compares to two's-complement signed.
module maxpool_2x2 #(
  parameter int CO     = 3,
  parameter int I_F_BW = 20,
  parameter int IX     = 24,
  parameter int IY     = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_in_valid,
  input  logic [CO*I_F_BW-1:0] i_in_fmap,
  output logic                 o_ot_valid,
  output logic [CO*I_F_BW-1:0] o_ot_fmap,
  output logic                 o_frame_done
);

  localparam int FW       = CO * I_F_BW;
  localparam int CW       = (IX > 1) ? $clog2(IX) : 1;
  localparam int RW       = (IY > 1) ? $clog2(IY) : 1;
  localparam int LB_DEPTH = IX / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IY - 1);

  function automatic logic [I_F_BW-1:0] elem_max(input logic [I_F_BW-1:0] a,
                                                  input logic [I_F_BW-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
    return ($signed(a) >= $signed(b)) ? a : b;
`else
    return (a >= b) ? a : b;
`endif
  endfunction

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [FW-1:0] h_prev;
  logic [FW-1:0] lbuf [LB_DEPTH];

  logic          col_odd_p0;
  logic          row_odd_p0;
  logic          col_last_p0;
  logic          row_last_p0;
  logic          lb_wr_p0;
  logic          pool_p0;
  logic [AW-1:0] lb_addr_p0;
  logic [FW-1:0] lb_rd_p0;
  logic [FW-1:0] h_max_p0;
  logic [FW-1:0] v_max_p0;

  logic          vld_p1;
  logic          done_p1;
  logic [FW-1:0] fmap_p1;

  // Stage p0: decode raster position of the incoming beat and form window maxima
  assign col_odd_p0  = col_cnt[0];
  assign row_odd_p0  = row_cnt[0];
  assign col_last_p0 = (col_cnt == COL_LAST);
  assign row_last_p0 = (row_cnt == ROW_LAST);
  assign lb_addr_p0  = AW'(col_cnt >> 1);
  assign lb_wr_p0    = i_in_valid && col_odd_p0 && !row_odd_p0;
  assign pool_p0     = i_in_valid && col_odd_p0 && row_odd_p0;
  assign lb_rd_p0    = lbuf[lb_addr_p0];

  for (genvar c = 0; c < CO; c++) begin : g_lane
    assign h_max_p0[c*I_F_BW +: I_F_BW] = elem_max(h_prev[c*I_F_BW +: I_F_BW],
                                                   i_in_fmap[c*I_F_BW +: I_F_BW]);
    assign v_max_p0[c*I_F_BW +: I_F_BW] = elem_max(lb_rd_p0[c*I_F_BW +: I_F_BW],
                                                   h_max_p0[c*I_F_BW +: I_F_BW]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (i_in_valid) begin
      if (col_last_p0) begin
        col_cnt <= '0;
        row_cnt <= row_last_p0 ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_prev <= '0;
    end else if (i_in_valid && !col_odd_p0) begin
      h_prev <= i_in_fmap;
    end
  end

  // Every entry is rewritten on an even row before the odd row reads it, so no reset
  always_ff @(posedge clk) begin
    if (lb_wr_p0) begin
      lbuf[lb_addr_p0] <= h_max_p0;
    end
  end

  // Stage p1: registered pooled output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      fmap_p1 <= '0;
    end else begin
      vld_p1  <= pool_p0;
      done_p1 <= pool_p0 && col_last_p0 && row_last_p0;
      if (pool_p0) begin
        fmap_p1 <= v_max_p0;
      end
    end
  end

  assign o_ot_valid   = vld_p1;
  assign o_frame_done = done_p1;
  assign o_ot_fmap    = fmap_p1;

endmodule

// File: doc/maxpool_2x2.md
# maxpool_2x2

Streaming 2x2 stride-2 max-pooling stage placed directly downstream of the convolution core, consuming its post-ReLU raster feature-map stream. All CO channels are pooled in parallel. For each 2x2 window of each channel the block emits the maximum element, reducing an IX x IY map to (IX/2) x (IY/2). Its output feeds the next conv layer or the flatten/FC stage.

## Interface
Parameters:
- CO, 3, channels pooled in parallel; must match the upstream output channel count.
- I_F_BW, 20, bit width per channel element, used for both input and output.
- IX, 24, input row length in valid beats; even, at least 2.
- IY, 24, input rows per frame; even, at least 2.

Ports:
- clk  in  1  the single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_in_valid  in  1  input beat strobe; one raster pixel for all channels.
- i_in_fmap  in  CO*I_F_BW  channel c occupies bits [c*I_F_BW +: I_F_BW].
- o_ot_valid  out  1  single-cycle strobe per pooled pixel.
- o_ot_fmap  out  CO*I_F_BW  pooled maxima, same channel packing as the input.
- o_frame_done  out  1  pulses together with the last pooled pixel of each frame.

## Operation
- Counters:
  - col_cnt runs 0..IX-1 and row_cnt runs 0..IY-1.
  - Both advance only on i_in_valid.
  - col_cnt wraps to 0 at IX-1 and increments row_cnt at that point.
  - row_cnt wraps to 0 at IY-1 when col_cnt also wraps. This is the frame end.
- Horizontal stage, per channel:
  - On an even-column beat, latch the pixel into h_prev.
  - On an odd-column beat, h_max = max(h_prev, pixel).
- Line buffer, per channel: IX/2 entries of I_F_BW bits, addressed by col_cnt>>1.
  - Even row, odd column: write h_max to lbuf[col_cnt>>1].
  - Odd row, odd column: compute max(lbuf[col_cnt>>1], h_max) into the output register and assert o_ot_valid.
- Compare:
  - Unsigned by default; see Configuration.
  - Ties select either operand, since the values are equal.
  - No arithmetic is performed, so there is no width growth or saturation.
- Per frame the block produces exactly (IX/2)*(IY/2) output strobes.
- o_frame_done is asserted with the output produced from the beat where row_cnt=IY-1 and col_cnt=IX-1.
- Gaps in i_in_valid of any length are allowed.
  - All state holds during a gap.
  - Output values are unaffected by gaps.
- Upstream must not present more than IX*IY beats between frames. The block has no backpressure: it accepts every valid beat.

## Timing
- Reset values:
  - o_ot_valid=0, o_frame_done=0, o_ot_fmap=0.
  - col_cnt=0, row_cnt=0, h_prev=0.
  - The line buffer is not reset. Every entry is written on an even row before it is read on the following odd row.
- Latency: o_ot_valid rises exactly 1 clk after the qualifying odd-row, odd-column input beat.
- o_ot_fmap holds its value until the next output strobe.
- Output strobes are at least 2 cycles apart. Back-to-back input beats give an output every other beat, on odd rows only.
- Reset mid-frame:
  - Counters return to 0 immediately and the partial window is discarded.
  - The next valid beat is treated as pixel (0,0) of a new frame.
  - Any strobe that was due is cancelled.
- Frame wrap: the first beat after the frame-end beat is (0,0). Back-to-back frames need no idle cycle.

## Configuration
- MAXPOOL_SIGNED_EN defined:
  - Compares treat each element as two's-complement signed.
  - Required when the pooling stage precedes ReLU, so negative values are pooled correctly.
- MAXPOOL_SIGNED_EN undefined: compares are unsigned.
- Ports, latency and reset values are identical in both builds.

## Test plan
- Single 4x4 frame, CO=1, IX=IY=4, pixels 0..15 in raster order, back-to-back:
  - Outputs are 5, 7, 13, 15.
  - Each strobe comes 1 cycle after input beats 5, 7, 13 and 15 respectively.
  - o_frame_done is asserted with the value 15.
- Same frame with i_in_valid toggling 1/0 every cycle: identical output values, with strobes 1 cycle after the same beats.
- Max in each window position: 4x4 frame with 100 placed at (0,0), (1,3), (2,1) and (3,2), all other pixels 1 → outputs 100, 100, 100, 100.
- Per-channel independence: CO=3, channel c pixel = c*16 + raster index → three output lanes 5/7/13/15, 21/23/29/31 and 37/39/45/47.
- Reset mid-frame: assert reset_n=0 after beat 6, then feed a full frame.
  - No strobe appears from the aborted frame.
  - The full frame yields exactly 4 outputs.
- Signedness, window {-3, -1, -8, -2} with I_F_BW=20:
  - With MAXPOOL_SIGNED_EN, output is -1 (20'hFFFFF).
  - Without it, output is 20'hFFFFF (the largest unsigned value, 2^20-1).
  - Second window {5, -1, 0, 2}: signed gives 5, unsigned gives 20'hFFFFF.
